// File: rtl/perf_counter_unit_pkg.sv
// rtl/perf_counter_unit_pkg.sv - shared types, saturation constant and clear decode for the perf counters
package perf_counter_unit_pkg;

   localparam int unsigned LC3B_WORD_W = 16;
   localparam int unsigned NUM_CTRS    = 7;

   typedef logic [LC3B_WORD_W-1:0] lc3b_word;

   localparam lc3b_word CTR_SAT = 16'hFFFF;

   typedef enum logic [2:0] {
      CTR_BUBBLE = 3'd0,
      CTR_L1I_RD = 3'd1,
      CTR_L1I_WR = 3'd2,
      CTR_L1D_RD = 3'd3,
      CTR_L1D_WR = 3'd4,
      CTR_L2_RD  = 3'd5,
      CTR_L2_WR  = 3'd6,
      CTR_ALL    = 3'd7
   } lc3b_ctr_sel;

   // One strobe per counter; bit position equals the lc3b_ctr_sel encoding.
   function automatic logic [NUM_CTRS-1:0] ctr_clr_decode(input logic        clr_take,
                                                          input lc3b_ctr_sel sel);
      logic [NUM_CTRS-1:0] strobes;
      strobes = '0;
      if (clr_take) begin
         if (sel == CTR_ALL) begin
            strobes = '1;
         end else begin
            strobes[sel] = 1'b1;
         end
      end
      return strobes;
   endfunction

endpackage

// File: rtl/perf_counter_unit_event_counter.sv
// rtl/perf_counter_unit_event_counter.sv - saturating event counter, level or rising-edge qualified
module event_counter
   import perf_counter_unit_pkg::*;
#(
   parameter int unsigned width     = 16,
   parameter bit          edge_mode = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             ev,
   input  logic             clr,
   output logic [width-1:0] count
);

   localparam logic [width-1:0] sat_value = width'(CTR_SAT);

   logic prev;
   logic hit;
   logic inc;

   // prev follows the input even while frozen, so an edge seen with en=0 is consumed.
   assign hit = edge_mode ? (ev & ~prev) : ev;
   assign inc = hit & en & (count != sat_value);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         prev  <= 1'b0;
      end else begin
         prev <= ev;
         if (clr) begin
            count <= '0;
         end else if (inc) begin
            count <= count + width'(1);
         end
      end
   end

endmodule

// File: rtl/perf_counter_unit.sv
// rtl/perf_counter_unit.sv - seven saturating performance counters read back by the execute stage
module perf_counter_unit
   import perf_counter_unit_pkg::*;
#(
   parameter int unsigned width = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             count_en,
   input  logic             bubble_in,
   input  logic             l1i_rd_miss_in,
   input  logic             l1i_wr_miss_in,
   input  logic             l1d_rd_miss_in,
   input  logic             l1d_wr_miss_in,
   input  logic             l2_rd_miss_in,
   input  logic             l2_wr_miss_in,
   input  logic             clr_valid,
   input  logic [2:0]       clr_sel,
   input  logic             stall,
   output logic [width-1:0] bubble_count,
   output logic [width-1:0] l1i_read_miss,
   output logic [width-1:0] l1i_write_miss,
   output logic [width-1:0] l1d_read_miss,
   output logic [width-1:0] l1d_write_miss,
   output logic [width-1:0] l2_read_miss,
   output logic [width-1:0] l2_write_miss
);

   logic                clr_take;
   logic [NUM_CTRS-1:0] clr;

   assign clr_take = clr_valid & ~stall;
   assign clr      = ctr_clr_decode(clr_take, lc3b_ctr_sel'(clr_sel));

   event_counter #(.width(width), .edge_mode(1'b0)) u_bubble (
      .clk   (clk),
      .reset (reset),
      .en    (count_en),
      .ev    (bubble_in),
      .clr   (clr[CTR_BUBBLE]),
      .count (bubble_count)
   );

   event_counter #(.width(width), .edge_mode(1'b1)) u_l1i_rd (
      .clk   (clk),
      .reset (reset),
      .en    (count_en),
      .ev    (l1i_rd_miss_in),
      .clr   (clr[CTR_L1I_RD]),
      .count (l1i_read_miss)
   );

   event_counter #(.width(width), .edge_mode(1'b1)) u_l1i_wr (
      .clk   (clk),
      .reset (reset),
      .en    (count_en),
      .ev    (l1i_wr_miss_in),
      .clr   (clr[CTR_L1I_WR]),
      .count (l1i_write_miss)
   );

   event_counter #(.width(width), .edge_mode(1'b1)) u_l1d_rd (
      .clk   (clk),
      .reset (reset),
      .en    (count_en),
      .ev    (l1d_rd_miss_in),
      .clr   (clr[CTR_L1D_RD]),
      .count (l1d_read_miss)
   );

   event_counter #(.width(width), .edge_mode(1'b1)) u_l1d_wr (
      .clk   (clk),
      .reset (reset),
      .en    (count_en),
      .ev    (l1d_wr_miss_in),
      .clr   (clr[CTR_L1D_WR]),
      .count (l1d_write_miss)
   );

   event_counter #(.width(width), .edge_mode(1'b1)) u_l2_rd (
      .clk   (clk),
      .reset (reset),
      .en    (count_en),
      .ev    (l2_rd_miss_in),
      .clr   (clr[CTR_L2_RD]),
      .count (l2_read_miss)
   );

   event_counter #(.width(width), .edge_mode(1'b1)) u_l2_wr (
      .clk   (clk),
      .reset (reset),
      .en    (count_en),
      .ev    (l2_wr_miss_in),
      .clr   (clr[CTR_L2_WR]),
      .count (l2_write_miss)
   );

endmodule
